// File: rtl/sc_regdeshifter_pkg.sv
// rtl/sc_regdeshifter_pkg.sv - shared state and direction encodings for the receive deshifter
package sc_regdeshifter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RECEIVE = 1'b1
  } state_e;

  localparam logic MSBFIRST = 1'b0;
  localparam logic LSBFIRST = 1'b1;

endpackage

// File: rtl/sc_regdeshifter_bitcounter.sv
// rtl/sc_regdeshifter_bitcounter.sv - bit counter with sync clear, increment and terminal count
module sc_regdeshifter_bitcounter #(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                inc_i,
  output logic [CNTWIDTH-1:0] count_o,
  output logic                tc_o
);

  logic [CNTWIDTH-1:0] count_q;
  logic [CNTWIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CNTWIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CNTWIDTH'(DATAWIDTH - 1));

endmodule

// File: rtl/sc_regdeshifter.sv
// rtl/sc_regdeshifter.sv - serial-to-parallel receive shifter with held output and ready/ack handshake
module sc_regdeshifter
  import sc_regdeshifter_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 4
) (
  input  logic                 SC_REGSHIFTER_CLOCK_50,
  input  logic                 SC_REGSHIFTER_RESET_InHigh,
  input  logic                 SC_REGDESHIFTER_clear_InLow,
  input  logic                 SC_REGDESHIFTER_enable_InLow,
  input  logic                 SC_REGDESHIFTER_lsbfirst_In,
  input  logic                 SC_REGDESHIFTER_serial_In,
  input  logic                 SC_REGDESHIFTER_bitvalid_In,
  input  logic                 SC_REGDESHIFTER_ack_In,
  output logic [DATAWIDTH-1:0] SC_REGDESHIFTER_data_OutBUS,
  output logic                 SC_REGDESHIFTER_ready_Out,
  output logic                 SC_REGDESHIFTER_busy_Out,
  output logic                 SC_REGDESHIFTER_overrun_Out,
  output logic [CNTWIDTH-1:0]  SC_REGDESHIFTER_bitcount_OutBUS
);

  state_e               state_q;
  logic [DATAWIDTH-1:0] sreg_q;
  logic [DATAWIDTH-1:0] sreg_d;
  logic [DATAWIDTH-1:0] data_q;
  logic                 dir_q;
  logic                 dir_w;
  logic                 ready_q;
  logic                 overrun_q;
  logic                 shift_w;
  logic                 last_w;
  logic                 tc_w;
  logic                 cnt_clear_w;
  logic                 cnt_inc_w;

  assign shift_w = SC_REGDESHIFTER_clear_InLow & ~SC_REGDESHIFTER_enable_InLow
                 & SC_REGDESHIFTER_bitvalid_In;
  assign last_w  = shift_w & (state_q == ST_RECEIVE) & tc_w;

  assign cnt_clear_w = ~SC_REGDESHIFTER_clear_InLow | SC_REGDESHIFTER_enable_InLow | last_w;
  assign cnt_inc_w   = shift_w & ~last_w;

  // The first bit of a word uses the live direction input; later bits use the latched one.
  assign dir_w  = (state_q == ST_IDLE) ? SC_REGDESHIFTER_lsbfirst_In : dir_q;
  assign sreg_d = (dir_w == LSBFIRST) ? {SC_REGDESHIFTER_serial_In, sreg_q[DATAWIDTH-1:1]}
                                      : {sreg_q[DATAWIDTH-2:0], SC_REGDESHIFTER_serial_In};

  sc_regdeshifter_bitcounter #(
    .DATAWIDTH(DATAWIDTH),
    .CNTWIDTH (CNTWIDTH)
  ) u_bitcounter (
    .clk_i  (SC_REGSHIFTER_CLOCK_50),
    .rst_i  (SC_REGSHIFTER_RESET_InHigh),
    .clear_i(cnt_clear_w),
    .inc_i  (cnt_inc_w),
    .count_o(SC_REGDESHIFTER_bitcount_OutBUS),
    .tc_o   (tc_w)
  );

  always_ff @(posedge SC_REGSHIFTER_CLOCK_50 or posedge SC_REGSHIFTER_RESET_InHigh) begin
    if (SC_REGSHIFTER_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      data_q    <= '0;
      dir_q     <= MSBFIRST;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!SC_REGDESHIFTER_clear_InLow) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      data_q    <= '0;
      dir_q     <= MSBFIRST;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (SC_REGDESHIFTER_enable_InLow) begin
        state_q <= ST_IDLE;
      end else if (shift_w) begin
        sreg_q <= sreg_d;
        if (state_q == ST_IDLE) begin
          dir_q   <= SC_REGDESHIFTER_lsbfirst_In;
          state_q <= ST_RECEIVE;
        end else if (last_w) begin
          state_q <= ST_IDLE;
        end
      end
      // A completed word only replaces the held one if it has been or is being consumed.
      if (last_w) begin
        if (!ready_q || SC_REGDESHIFTER_ack_In) begin
          data_q  <= sreg_d;
          ready_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (SC_REGDESHIFTER_ack_In) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign SC_REGDESHIFTER_data_OutBUS = data_q;
  assign SC_REGDESHIFTER_ready_Out   = ready_q;
  assign SC_REGDESHIFTER_busy_Out    = (state_q == ST_RECEIVE);
  assign SC_REGDESHIFTER_overrun_Out = overrun_q;

endmodule

// File: tb/tb_sc_regdeshifter.sv
// tb/tb_sc_regdeshifter.sv - directed self-checking bench for sc_regdeshifter
module tb_sc_regdeshifter;

  logic       clk;
  logic       rst;
  logic       clear_n;
  logic       enable_n;
  logic       lsbfirst;
  logic       serial;
  logic       bitvalid;
  logic       ack;
  logic [7:0] data;
  logic       ready;
  logic       busy;
  logic       overrun;
  logic [3:0] bitcount;

  int total = 0;
  int bad   = 0;

  sc_regdeshifter #(.DATAWIDTH(8), .CNTWIDTH(4)) dut (
    .SC_REGSHIFTER_CLOCK_50         (clk),
    .SC_REGSHIFTER_RESET_InHigh     (rst),
    .SC_REGDESHIFTER_clear_InLow    (clear_n),
    .SC_REGDESHIFTER_enable_InLow   (enable_n),
    .SC_REGDESHIFTER_lsbfirst_In    (lsbfirst),
    .SC_REGDESHIFTER_serial_In      (serial),
    .SC_REGDESHIFTER_bitvalid_In    (bitvalid),
    .SC_REGDESHIFTER_ack_In         (ack),
    .SC_REGDESHIFTER_data_OutBUS    (data),
    .SC_REGDESHIFTER_ready_Out      (ready),
    .SC_REGDESHIFTER_busy_Out       (busy),
    .SC_REGDESHIFTER_overrun_Out    (overrun),
    .SC_REGDESHIFTER_bitcount_OutBUS(bitcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sends bits [from, to) of a word; bit order follows lsb, toggle flips lsbfirst_In after bit 0.
  task automatic send_bits(input logic [7:0] w, input logic lsb, input int from, input int to,
                           input int gap, input logic toggle, input logic ack_last);
    for (int i = from; i < to; i++) begin
      lsbfirst = (toggle && i > 0) ? ~lsb : lsb;
      serial   = lsb ? w[i] : w[7-i];
      bitvalid = 1'b1;
      ack      = ack_last && (i == 7);
      tick();
      bitvalid = 1'b0;
      ack      = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear_n = 1'b1; enable_n = 1'b0; lsbfirst = 1'b0;
    serial = 1'b0; bitvalid = 1'b0; ack = 1'b0;
    tick(); tick();
    check("rst_data", data, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_bitcount", bitcount, 0);
    rst = 1'b0;
    tick();

    // MSB-first 0xA5, back to back
    for (int i = 0; i < 8; i++) begin
      send_bits(8'hA5, 1'b0, i, i + 1, 0, 1'b0, 1'b0);
      if (i < 7) begin
        check("t1_busy", busy, 1);
        check("t1_count", bitcount, i + 1);
        check("t1_notready", ready, 0);
      end
    end
    check("t1_data", data, 8'hA5);
    check("t1_ready", ready, 1);
    check("t1_busy_end", busy, 0);
    check("t1_count_end", bitcount, 0);
    do_ack();
    check("t1_ack", ready, 0);

    // LSB-first 0xA3 with gaps, direction input toggled mid-word
    send_bits(8'hA3, 1'b1, 0, 8, 2, 1'b1, 1'b0);
    check("t2_data", data, 8'hA3);
    check("t2_ready", ready, 1);
    check("t2_busy", busy, 0);
    do_ack();
    lsbfirst = 1'b0;

    // Overrun, ack, clear
    send_bits(8'h11, 1'b0, 0, 8, 0, 1'b0, 1'b0);
    check("t3_data1", data, 8'h11);
    check("t3_ovr0", overrun, 0);
    send_bits(8'h22, 1'b0, 0, 8, 0, 1'b0, 1'b0);
    check("t3_data_kept", data, 8'h11);
    check("t3_ready", ready, 1);
    check("t3_ovr1", overrun, 1);
    do_ack();
    check("t3_ack_ready", ready, 0);
    check("t3_ack_ovr", overrun, 1);
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    check("t3_clr_data", data, 0);
    check("t3_clr_ready", ready, 0);
    check("t3_clr_ovr", overrun, 0);
    check("t3_clr_busy", busy, 0);
    check("t3_clr_count", bitcount, 0);

    // Completion with simultaneous ack replaces the held word
    send_bits(8'h11, 1'b0, 0, 8, 0, 1'b0, 1'b0);
    send_bits(8'h22, 1'b0, 0, 8, 0, 1'b0, 1'b1);
    check("t4_data", data, 8'h22);
    check("t4_ready", ready, 1);
    check("t4_ovr", overrun, 0);

    // Abort after 3 bits leaves the held word alone
    send_bits(8'hFF, 1'b0, 0, 3, 0, 1'b0, 1'b0);
    check("t5_count3", bitcount, 3);
    check("t5_busy3", busy, 1);
    enable_n = 1'b1;
    tick();
    enable_n = 1'b0;
    check("t5_abort_busy", busy, 0);
    check("t5_abort_count", bitcount, 0);
    check("t5_abort_ready", ready, 1);
    check("t5_abort_data", data, 8'h22);
    do_ack();
    send_bits(8'h0F, 1'b0, 0, 8, 0, 1'b0, 1'b0);
    check("t5_data", data, 8'h0F);
    check("t5_ready", ready, 1);
    check("t5_ovr", overrun, 0);
    do_ack();

    // Asynchronous reset mid-word, mid-cycle
    send_bits(8'hF0, 1'b0, 0, 4, 0, 1'b0, 1'b0);
    check("t6_count4", bitcount, 4);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_data", data, 0);
    check("t6_rst_ready", ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", bitcount, 0);
    check("t6_rst_ovr", overrun, 0);
    #1;
    rst = 1'b0;
    tick();
    send_bits(8'h81, 1'b0, 0, 8, 0, 1'b0, 1'b0);
    check("t6_data", data, 8'h81);
    check("t6_ready", ready, 1);
    check("t6_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
